// File: rtl/l2_responder.sv
// l2_responder: single-outstanding word memory that answers read/write requests.
// Latency: resp_valid rises L2_DELAY cycles after the request acceptance edge.
// Backpressure: req_ready only in IDLE; the response is held stable until resp_ready.
module l2_responder #(
    parameter int WORD_SIZE  = 32,
    parameter int L2_DELAY   = 3,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_wr_en,
    input  logic [WORD_SIZE-1:0] req_addr,
    input  logic [WORD_SIZE-1:0] req_data,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [WORD_SIZE-1:0] resp_data
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = (L2_DELAY > 1) ? $clog2(L2_DELAY) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CNT_W-1:0]        r_cnt;
    logic [DEPTH_LOG2-1:0]   r_addr;
    logic                    r_wr;
    logic [WORD_SIZE-1:0]    r_wdata;
    logic [WORD_SIZE-1:0]    r_resp_data;
    logic [WORD_SIZE-1:0]    r_mem [DEPTH];

    logic                    w_accept;
    logic                    w_wait_done;
    logic [DEPTH_LOG2-1:0]   w_idx;

    assign req_ready   = (r_state == S_IDLE);
    assign resp_valid  = (r_state == S_RESP);
    assign resp_data   = r_resp_data;
    assign w_accept    = req_valid & req_ready;
    assign w_wait_done = (r_state == S_WAIT) && (r_cnt == '0);
    assign w_idx       = req_addr[DEPTH_LOG2-1:0];

    // Upper address bits alias onto the same storage and are intentionally dropped.
    generate
        if (WORD_SIZE > DEPTH_LOG2) begin : g_addr_hi
            logic w_addr_hi_unused;
            assign w_addr_hi_unused = ^req_addr[WORD_SIZE-1:DEPTH_LOG2];
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: accept in IDLE, count out latency in WAIT, hold in RESP
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (req_valid)   w_state_nxt = S_WAIT;
            S_WAIT:  if (r_cnt == '0) w_state_nxt = S_RESP;
            S_RESP:  if (resp_ready)  w_state_nxt = S_IDLE;
            default:                  w_state_nxt = S_IDLE;
        endcase
    end

    // Latency counter: loaded on acceptance, saturates at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= CNT_W'(L2_DELAY - 1);
        end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Capture the accepted request for use when the response is formed
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= '0;
            r_wr    <= 1'b0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_addr  <= w_idx;
            r_wr    <= req_wr_en;
            r_wdata <= req_data;
        end
    end

    // Storage: cleared by reset, writes commit at the acceptance edge
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_accept && req_wr_en) begin
            r_mem[w_idx] <= req_data;
        end
    end

    // Response word: registered on the WAIT->RESP edge, then frozen through RESP
    always_ff @(posedge clk) begin
        if (rst) begin
            r_resp_data <= '0;
        end else if (w_wait_done) begin
            r_resp_data <= r_wr ? r_wdata : r_mem[r_addr];
        end
    end

endmodule

// File: tb/tb_l2_responder.sv
// tb_l2_responder: directed and random request/response traffic against a word-array model.
// Latency: checks response timing against L2_DELAY for a default and a single-cycle instance.
// Backpressure: holds resp_ready low for varying durations and checks response stability.
module tb_l2_responder;

    localparam int DLY_A = 3;

    logic        clk = 1'b0;
    logic        rst;

    logic        req_valid,  req_ready,  req_wr_en,  resp_valid,  resp_ready;
    logic [31:0] req_addr,   req_data,   resp_data;
    logic        req_valid_b, req_ready_b, req_wr_en_b, resp_valid_b, resp_ready_b;
    logic [31:0] req_addr_b,  req_data_b,  resp_data_b;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model [256];

    always #5 clk = ~clk;

    l2_responder #(.WORD_SIZE(32), .L2_DELAY(DLY_A), .DEPTH_LOG2(8)) u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wr_en  (req_wr_en),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data)
    );

    l2_responder #(.WORD_SIZE(32), .L2_DELAY(1), .DEPTH_LOG2(8)) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid_b),
        .req_ready  (req_ready_b),
        .req_wr_en  (req_wr_en_b),
        .req_addr   (req_addr_b),
        .req_data   (req_data_b),
        .resp_valid (resp_valid_b),
        .resp_ready (resp_ready_b),
        .resp_data  (resp_data_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 256; i++) model[i] = 32'h0;
    endtask

    // Full request on instance A: expected data and latency come from the model.
    task automatic txn(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                       input int hold, input string tag);
        logic [31:0] exp;
        int          lat;
        exp = wr ? data : model[addr[7:0]];
        if (wr) model[addr[7:0]] = data;
        @(negedge clk);
        check({tag, "_rdy_in"}, req_ready, 1);
        req_valid = 1'b1; req_wr_en = wr; req_addr = addr; req_data = data;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (resp_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, lat, DLY_A);
        check({tag, "_data"}, resp_data, exp);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check({tag, "_hold_vld"}, resp_valid, 1);
            check({tag, "_hold_data"}, resp_data, exp);
            check({tag, "_hold_rdy"}, req_ready, 0);
        end
        @(negedge clk); resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check({tag, "_done_rdy"}, req_ready, 1);
        check({tag, "_done_vld"}, resp_valid, 0);
    endtask

    // Request on the single-cycle-latency instance B.
    task automatic txn_b(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [31:0] exp, input string tag);
        @(negedge clk);
        req_valid_b = 1'b1; req_wr_en_b = wr; req_addr_b = addr; req_data_b = data;
        @(posedge clk); #1;
        req_valid_b = 1'b0;
        check({tag, "_wait_vld"}, resp_valid_b, 0);
        @(posedge clk); #1;
        check({tag, "_vld"}, resp_valid_b, 1);
        check({tag, "_data"}, resp_data_b, exp);
        @(negedge clk); resp_ready_b = 1'b1;
        @(posedge clk); #1;
        resp_ready_b = 1'b0;
        check({tag, "_done_rdy"}, req_ready_b, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int extra;
        rst = 1'b1;
        req_valid = 0; req_wr_en = 0; req_addr = 0; req_data = 0; resp_ready = 0;
        req_valid_b = 0; req_wr_en_b = 0; req_addr_b = 0; req_data_b = 0; resp_ready_b = 0;
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;

        // Reset state
        check("rst_req_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_b_req_ready", req_ready_b, 1);

        // Unwritten location reads zero
        txn(0, 32'h11, 32'h0, 0, "rd_unwritten");
        // Write then read back
        txn(1, 32'h10, 32'hA5A5A5A5, 0, "wr_10");
        txn(0, 32'h10, 32'h0, 0, "rd_10");
        // Response held under backpressure for 5 cycles
        txn(0, 32'h10, 32'h0, 5, "rd_10_hold");
        // Aliasing: 0x110 lands on the same word as 0x10
        txn(1, 32'h110, 32'h5A5A5A5A, 0, "wr_110");
        txn(0, 32'h10, 32'h0, 0, "rd_alias");

        // Request presented during WAIT is ignored
        @(negedge clk);
        req_valid = 1'b1; req_wr_en = 1'b0; req_addr = 32'h10; req_data = 32'h0;
        @(posedge clk); #1;
        req_wr_en = 1'b1; req_addr = 32'h30; req_data = 32'h12345678;
        check("ign_rdy0", req_ready, 0);
        @(posedge clk); #1;
        check("ign_rdy1", req_ready, 0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("ign_resp_vld", resp_valid, 1);
        check("ign_resp_data", resp_data, model[8'h10]);
        @(negedge clk); resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        extra = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (resp_valid === 1'b1) extra++;
        end
        check("ign_single_resp", extra, 0);
        txn(0, 32'h30, 32'h0, 0, "ign_rd_30");

        // Reset during WAIT discards the request and clears storage
        @(negedge clk);
        req_valid = 1'b1; req_wr_en = 1'b1; req_addr = 32'h30; req_data = 32'h12345678;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("rstw_resp_vld", resp_valid, 0);
        check("rstw_req_rdy", req_ready, 1);
        check("rstw_resp_data", resp_data, 0);
        @(negedge clk); rst = 1'b0;
        model_clear();
        extra = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (resp_valid === 1'b1) extra++;
        end
        check("rstw_no_resp", extra, 0);
        txn(0, 32'h30, 32'h0, 0, "rstw_rd_30");
        txn(0, 32'h10, 32'h0, 0, "rstw_rd_10");

        // Write presented at the same edge as reset does not commit
        @(negedge clk);
        rst = 1'b1;
        req_valid = 1'b1; req_wr_en = 1'b1; req_addr = 32'h44; req_data = 32'hCAFEF00D;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rstacc_rdy", req_ready, 1);
        check("rstacc_vld", resp_valid, 0);
        @(negedge clk); rst = 1'b0;
        model_clear();
        txn(0, 32'h44, 32'h0, 0, "rstacc_rd_44");

        // Single-cycle latency instance
        txn_b(0, 32'h20, 32'h0, 32'h0, "b_rd_20");
        txn_b(1, 32'h20, 32'hDEADBEEF, 32'hDEADBEEF, "b_wr_20");
        txn_b(0, 32'h120, 32'h0, 32'hDEADBEEF, "b_rd_alias");

        // Random traffic against the model, with aliasing upper address bits
        for (int n = 0; n < 40; n++) begin
            bit          wr;
            logic [31:0] addr, data;
            int          hold;
            wr   = 1'($urandom_range(0, 1));
            addr = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 15));
            data = $urandom;
            hold = $urandom_range(0, 3);
            txn(wr, addr, data, hold, "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/l2_responder.md
L2_RESPONDER -- requirements
Module: l2_responder

Interface
REQ-001 Parameter WORD_SIZE, default 32: width of the address and data words.
REQ-002 Parameter L2_DELAY, default 3: number of cycles from request acceptance to response valid; legal values are 1 or greater.
REQ-003 Parameter DEPTH_LOG2, default 8: log2 of the storage depth in words.
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port req_valid, input, 1 bit: the requester presents a request.
REQ-007 Port req_ready, output, 1 bit: the responder can accept a request.
REQ-008 Port req_wr_en, input, 1 bit: 1 selects write, 0 selects read.
REQ-009 Port req_addr, input, WORD_SIZE bits: word address.
REQ-010 Port req_data, input, WORD_SIZE bits: write data.
REQ-011 Port resp_valid, output, 1 bit: a response is present.
REQ-012 Port resp_ready, input, 1 bit: the requester accepts the response.
REQ-013 Port resp_data, output, WORD_SIZE bits: read data, or the echoed write data.

Function
REQ-014 Storage SHALL be 2^DEPTH_LOG2 words, indexed by req_addr[DEPTH_LOG2-1:0]; upper address bits SHALL be ignored, so addresses alias.
REQ-015 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-016 req_ready SHALL be 1 exactly when the state is IDLE, decoded from the state only.
REQ-017 Acceptance SHALL occur at a rising edge where req_valid=1 and req_ready=1; at that edge the address, wr_en and data SHALL be latched and the FSM SHALL move to WAIT with the latency counter loaded to L2_DELAY-1.
REQ-018 A write SHALL commit req_data to storage at the acceptance edge.
REQ-019 In WAIT, the counter SHALL decrement by 1 each cycle. At the edge where the counter equals 0, the FSM SHALL move to RESP and register resp_data: the storage word for a read, the latched data for a write.
REQ-020 resp_valid SHALL be 1 exactly in RESP, so it is first high L2_DELAY cycles after the acceptance edge.
REQ-021 In RESP, resp_data SHALL stay stable while resp_ready=0, with no timeout.
REQ-022 At an edge in RESP where resp_ready=1, the FSM SHALL return to IDLE; req_ready SHALL be 1 in the following cycle; there is no same-cycle turnaround.
REQ-023 req_valid in WAIT or RESP SHALL be ignored, with no storage change and no queuing; at most one request is outstanding.
REQ-024 resp_ready outside RESP SHALL have no effect.
REQ-025 The latency counter SHALL be $clog2(L2_DELAY) bits wide, with a minimum of 1 bit; it SHALL never wrap below 0.
REQ-026 A read of a location never written since reset SHALL return 0.

Reset
REQ-027 An edge with rst=1 SHALL force state IDLE, counter 0, resp_valid=0, resp_data=0, req_ready=1 on the following cycle, and clear every storage word to 0.
REQ-028 rst SHALL take priority over every handshake at the same edge; a request in WAIT or RESP SHALL be discarded with no response, and a write accepted at that same edge SHALL NOT commit.

Verification
REQ-029 The bench SHALL cover: write 0xA5A5A5A5 to 0x10 -> resp_valid high exactly 3 cycles after acceptance with resp_data=0xA5A5A5A5; then read 0x10 -> 0xA5A5A5A5 after 3 cycles.
REQ-030 The bench SHALL cover: read 0x11 after reset with no prior write -> resp_data=0x00000000, resp_valid after 3 cycles.
REQ-031 The bench SHALL cover: read 0x10 with resp_ready held 0 for 5 cycles -> resp_valid and resp_data=0xA5A5A5A5 held stable and req_ready=0 throughout; resp_ready=1 -> IDLE next edge, req_ready=1.
REQ-032 The bench SHALL cover: with DEPTH_LOG2=8, write 0x5A5A5A5A to 0x110, then read 0x10 -> 0x5A5A5A5A, proving aliasing.
REQ-033 The bench SHALL cover: during WAIT, drive a write of 0x12345678 to 0x30 -> ignored; a later read of 0x30 returns 0, and only one response is produced.
REQ-034 The bench SHALL cover: write 0x12345678 to 0x30, assert rst during WAIT -> no resp_valid, req_ready=1 after reset; a read of 0x30 returns 0x00000000.
REQ-035 The bench SHALL cover: L2_DELAY=1, read 0x20 -> resp_valid in the cycle immediately after the acceptance edge.
